// File: rtl/noc_flit_pkg.sv
// Shared flit-format definitions for the NoC ejection path: type encodings,
// destination field offsets and a constant-evaluable clog2.
package noc_flit_pkg;

  typedef enum logic [1:0] {
    FLIT_HEAD   = 2'b00,
    FLIT_BODY   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return result;
  endfunction

  // dst_x sits directly under the 2-bit type field, dst_y directly under dst_x.
  function automatic int dst_x_lsb(input int flit_w, input int coord_w);
    return flit_w - 2 - coord_w;
  endfunction

  function automatic int dst_y_lsb(input int flit_w, input int coord_w);
    return flit_w - 2 - 2 * coord_w;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Synchronous per-VC flit FIFO. A push into a full FIFO succeeds when a pop
// happens in the same cycle; head is the oldest entry and is valid while !empty.
module flit_fifo
  import noc_flit_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone say which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/packet_ejector.sv
// Local ejection port: per-VC admission FSMs with misroute/turnoff dropping,
// credit return, and packet-locked round-robin delivery to the processing element.
module packet_ejector
  import noc_flit_pkg::*;
#(
  parameter int FLIT_W  = 16,
  parameter int COORD_W = 2,
  parameter int NUM_VC  = 2,
  parameter int DEPTH   = 4,
  localparam int VC_W   = (NUM_VC > 1) ? clog2(NUM_VC) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic               turnoff,
  input  logic               in_valid,
  input  logic [FLIT_W-1:0]  flit,
  input  logic [VC_W-1:0]    in_vc,
  output logic [NUM_VC-1:0]  credit,
  output logic               out_valid,
  output logic [FLIT_W-1:0]  out_flit,
  output logic [VC_W-1:0]    out_vc,
  output logic               out_last,
  input  logic               out_ready,
  output logic               misroute,
  output logic               overflow,
  output logic               idle
);
  localparam int DX_LSB = dst_x_lsb(FLIT_W, COORD_W);
  localparam int DY_LSB = dst_y_lsb(FLIT_W, COORD_W);

  typedef enum logic [1:0] {VC_IDLE, VC_RECV, VC_DROP} vc_state_e;

  vc_state_e         state_q [NUM_VC];
  vc_state_e         state_d [NUM_VC];
  logic [1:0]        pending_q [NUM_VC];
  logic [1:0]        pending_d [NUM_VC];
  logic [2:0]        pend_sum [NUM_VC];
  logic [NUM_VC-1:0] credit_q, credit_d;
  logic              misroute_q, misroute_d, overflow_q, overflow_d;
  logic              lock_q, lock_d, stall_q, stall_d;
  logic [VC_W-1:0]   ptr_q, ptr_d, hold_vc_q, hold_vc_d;

  logic [NUM_VC-1:0] push, pop, full, empty;
  logic [FLIT_W-1:0] head [NUM_VC];

  flit_type_e        in_type, out_type;
  logic              is_start, dst_ok, want_write, discard;
  logic [VC_W-1:0]   sel_vc, rr_vc;
  logic              sel_valid, rr_found, fire, all_quiet;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    flit_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[v]),
      .pop   (pop[v]),
      .din   (flit),
      .full  (full[v]),
      .empty (empty[v]),
      .head  (head[v])
    );
  end

  assign in_type  = flit_type_e'(flit[FLIT_W-1 -: 2]);
  assign is_start = (in_type == FLIT_HEAD) || (in_type == FLIT_SINGLE);
  assign dst_ok   = (flit[DX_LSB +: COORD_W] == X) && (flit[DY_LSB +: COORD_W] == Y);

  // Arbiter: a stalled or packet-locked grant is held; otherwise search from ptr_q.
  always_comb begin
    rr_vc    = ptr_q;
    rr_found = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!rr_found && !empty[(int'(ptr_q) + i) % NUM_VC]) begin
        rr_found = 1'b1;
        rr_vc    = VC_W'((int'(ptr_q) + i) % NUM_VC);
      end
    end
    if (lock_q || stall_q) begin
      sel_vc    = hold_vc_q;
      sel_valid = !empty[hold_vc_q];
    end else begin
      sel_vc    = rr_vc;
      sel_valid = rr_found;
    end
  end

  assign out_valid = sel_valid;
  assign out_vc    = sel_vc;
  assign out_flit  = head[sel_vc];
  assign out_type  = flit_type_e'(out_flit[FLIT_W-1 -: 2]);
  assign out_last  = (out_type == FLIT_TAIL) || (out_type == FLIT_SINGLE);
  assign fire      = out_valid && out_ready;

  always_comb begin
    pop       = '0;
    lock_d    = lock_q;
    ptr_d     = ptr_q;
    hold_vc_d = hold_vc_q;
    stall_d   = out_valid && !out_ready;
    if (out_valid) hold_vc_d = sel_vc;
    if (fire) begin
      pop[sel_vc] = 1'b1;
      lock_d      = !out_last;
      ptr_d       = VC_W'((int'(sel_vc) + 1) % NUM_VC);
    end
  end

  // Admission: only the FSM of in_vc moves, and only when in_valid is high.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    for (int v = 0; v < NUM_VC; v++) state_d[v] = state_q[v];
    want_write = 1'b0;
    discard    = 1'b0;
    misroute_d = 1'b0;
    overflow_d = overflow_q;
    push       = '0;
    if (in_valid) begin
      case (state_q[in_vc])
        VC_IDLE: begin
          if (!is_start) begin
            discard    = 1'b1;
            overflow_d = 1'b1;
          end else if (dst_ok && !turnoff) begin
            want_write = 1'b1;
            if (in_type == FLIT_HEAD) state_d[in_vc] = VC_RECV;
          end else begin
            discard    = 1'b1;
            misroute_d = !turnoff;
            if (in_type == FLIT_HEAD) state_d[in_vc] = VC_DROP;
          end
        end
        VC_RECV: begin
          if (is_start) begin
            discard    = 1'b1;
            overflow_d = 1'b1;
          end else begin
            want_write = 1'b1;
            if (in_type == FLIT_TAIL) state_d[in_vc] = VC_IDLE;
          end
        end
        VC_DROP: begin
          discard = 1'b1;
          if (is_start) overflow_d = 1'b1;
          else if (in_type == FLIT_TAIL) state_d[in_vc] = VC_IDLE;
        end
        default: state_d[in_vc] = VC_IDLE;
      endcase
    end
    if (want_write) begin
      if (full[in_vc] && !pop[in_vc]) overflow_d = 1'b1;
      else                            push[in_vc] = 1'b1;
    end
  end

  // A pop owns the credit bit; a coincident discard credit waits in pending_q.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      pend_sum[v] = {1'b0, pending_q[v]} + {2'b00, discard && (in_vc == VC_W'(v))};
      credit_d[v] = pop[v] || (pend_sum[v] != 3'd0);
      if (pop[v])                   pending_d[v] = (pend_sum[v] > 3'd3) ? 2'd3 : pend_sum[v][1:0];
      else if (pend_sum[v] != 3'd0) pending_d[v] = 2'(pend_sum[v] - 3'd1);
      else                          pending_d[v] = 2'd0;
    end
  end

  always_comb begin
    all_quiet = !lock_q && (&empty);
    for (int v = 0; v < NUM_VC; v++) begin
      if (state_q[v] != VC_IDLE || pending_q[v] != 2'd0) all_quiet = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v]   <= VC_IDLE;
        pending_q[v] <= 2'd0;
      end
      credit_q   <= '0;
      misroute_q <= 1'b0;
      overflow_q <= 1'b0;
      lock_q     <= 1'b0;
      stall_q    <= 1'b0;
      ptr_q      <= '0;
      hold_vc_q  <= '0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) begin
        state_q[v]   <= state_d[v];
        pending_q[v] <= pending_d[v];
      end
      credit_q   <= credit_d;
      misroute_q <= misroute_d;
      overflow_q <= overflow_d;
      lock_q     <= lock_d;
      stall_q    <= stall_d;
      ptr_q      <= ptr_d;
      hold_vc_q  <= hold_vc_d;
    end
  end

  assign credit   = credit_q;
  assign misroute = misroute_q;
  assign overflow = overflow_q;
  assign idle     = all_quiet;

endmodule

// File: tb/tb_packet_ejector.sv
// Bench for packet_ejector: a table of flits plus hand sequences, with a
// per-VC scoreboard and reference arbiter checking every output cycle.
module tb_packet_ejector;
  localparam int NUM_VC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  X = 2'b10;
  logic [1:0]  Y = 2'b00;
  logic        turnoff = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] flit = '0;
  logic        in_vc = 1'b0;
  logic [1:0]  credit;
  logic        out_valid;
  logic [15:0] out_flit;
  logic        out_vc;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic        misroute;
  logic        overflow;
  logic        idle;

  packet_ejector #(.FLIT_W(16), .COORD_W(2), .NUM_VC(NUM_VC), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .X(X), .Y(Y), .turnoff(turnoff),
    .in_valid(in_valid), .flit(flit), .in_vc(in_vc), .credit(credit),
    .out_valid(out_valid), .out_flit(out_flit), .out_vc(out_vc), .out_last(out_last),
    .out_ready(out_ready), .misroute(misroute), .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q [NUM_VC][$];
  logic [15:0] eject_log [$];
  int          cred_cnt [NUM_VC];
  int          mis_cnt = 0;

  int          m_ptr = 0, m_hold = 0, mon_vc = 0;
  logic        m_lock = 1'b0, m_stall = 1'b0;
  logic        mon_valid, mon_last;
  logic [15:0] mon_flit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference scoreboard and arbiter, sampled on the falling edge.
  always @(negedge clk) begin
    for (int v = 0; v < NUM_VC; v++) if (credit[v] === 1'b1) cred_cnt[v]++;
    if (misroute === 1'b1) mis_cnt++;
    mon_valid = 1'b0;
    mon_last  = 1'b0;
    mon_flit  = '0;
    if (m_lock || m_stall) begin
      mon_vc    = m_hold;
      mon_valid = (exp_q[m_hold].size() != 0);
    end else begin
      mon_vc = 0;
      for (int i = 0; i < NUM_VC; i++) begin
        if (!mon_valid && exp_q[(m_ptr + i) % NUM_VC].size() != 0) begin
          mon_valid = 1'b1;
          mon_vc    = (m_ptr + i) % NUM_VC;
        end
      end
    end
    check("out_valid", {31'd0, out_valid}, {31'd0, mon_valid});
    if (mon_valid) begin
      mon_flit = exp_q[mon_vc][0];
      mon_last = mon_flit[15];
      if (out_valid === 1'b1) begin
        check("out_vc", {31'd0, out_vc}, mon_vc);
        check("out_flit", {16'd0, out_flit}, {16'd0, mon_flit});
        check("out_last", {31'd0, out_last}, {31'd0, mon_last});
      end
    end
    if (reset) begin
      for (int v = 0; v < NUM_VC; v++) exp_q[v].delete();
      m_lock = 1'b0; m_stall = 1'b0; m_ptr = 0; m_hold = 0;
    end else begin
      m_stall = mon_valid && !out_ready;
      if (mon_valid) m_hold = mon_vc;
      if (mon_valid && out_ready) begin
        void'(exp_q[mon_vc].pop_front());
        eject_log.push_back(mon_flit);
        m_lock = !mon_last;
        m_ptr  = (mon_vc + 1) % NUM_VC;
      end
    end
  end

  task automatic drive(input logic vc, input logic [15:0] f, input logic acc);
    in_valid = 1'b1;
    in_vc    = vc;
    flit     = f;
    @(posedge clk);
    if (acc) exp_q[vc].push_back(f);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (idle !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_idle"}, {31'd0, idle}, 32'd1);
    wait_cycles(2);
  endtask

  task automatic check_log(input string name, input logic [15:0] exp [8], input int n);
    check({name, "_count"}, eject_log.size(), n);
    for (int i = 0; i < n && i < eject_log.size(); i++)
      check($sformatf("%s[%0d]", name, i), {16'd0, eject_log[i]}, {16'd0, exp[i]});
  endtask

  typedef struct {
    logic        vc;
    logic [15:0] flit;
    logic        rdy;
    logic        acc;
    logic        mis;
    logic        ovf;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] exp_log [8];
  logic [15:0] seq_a [4];
  logic [15:0] seq_b [4];
  int          c0, c1, m0;
  logic        ok_a, ok_b;

  initial begin
    cred_cnt[0] = 0;
    cred_cnt[1] = 0;
    // {vc, flit, out_ready, accepted, misroute next cycle, overflow}
    vecs[0] = '{1'b0, 16'h20AB, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h4011, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 16'h80CD, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h1055, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'hE012, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'hE001, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 16'hE002, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 16'hE003, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 16'hE004, 1'b0, 1'b1, 1'b0, 1'b0};

    wait_cycles(3);
    reset = 1'b0;
    check("rst_credit", {30'd0, credit}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_misroute", {31'd0, misroute}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);

    // Single packet, misroute, then round-robin contention between singles.
    for (int i = 0; i < 10; i++) begin
      out_ready = vecs[i].rdy;
      drive(vecs[i].vc, vecs[i].flit, vecs[i].acc);
      check($sformatf("vec%0d_misroute", i), {31'd0, misroute}, {31'd0, vecs[i].mis});
      check($sformatf("vec%0d_overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
    end
    wait_cycles(2);
    out_ready = 1'b1;
    wait_idle("table", 50);
    exp_log = '{16'h20AB, 16'h4011, 16'h80CD, 16'hE012, 16'hE001, 16'hE002, 16'hE003, 16'hE004};
    check_log("table_log", exp_log, 8);
    check("table_credit0", cred_cnt[0], 32'd5);
    check("table_credit1", cred_cnt[1], 32'd5);
    check("table_misroutes", mis_cnt, 32'd1);

    // Interleaved arrival with the sink stalled: packets must eject whole.
    eject_log.delete();
    c0 = cred_cnt[0]; c1 = cred_cnt[1];
    out_ready = 1'b0;
    drive(1'b0, 16'h20AB, 1'b1);
    drive(1'b1, 16'hE012, 1'b1);
    drive(1'b0, 16'h4011, 1'b1);
    drive(1'b0, 16'h80CD, 1'b1);
    wait_cycles(1);
    out_ready = 1'b1;
    wait_idle("interleave", 50);
    seq_a = '{16'h20AB, 16'h4011, 16'h80CD, 16'hE012};
    seq_b = '{16'hE012, 16'h20AB, 16'h4011, 16'h80CD};
    ok_a = (eject_log.size() == 4);
    ok_b = ok_a;
    for (int i = 0; i < 4 && i < eject_log.size(); i++) begin
      if (eject_log[i] != seq_a[i]) ok_a = 1'b0;
      if (eject_log[i] != seq_b[i]) ok_b = 1'b0;
    end
    check("interleave_whole_packets", {31'd0, ok_a || ok_b}, 32'd1);
    check("interleave_credit0", cred_cnt[0] - c0, 32'd3);
    check("interleave_credit1", cred_cnt[1] - c1, 32'd1);

    // Overflow: head + 4 bodies into a 4-deep VC with the sink stalled.
    eject_log.delete();
    c0 = cred_cnt[0];
    out_ready = 1'b0;
    drive(1'b0, 16'h20AB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h4011, 1'b1);
      check($sformatf("ovf_fill%0d", i), {31'd0, overflow}, 32'd0);
    end
    drive(1'b0, 16'h4011, 1'b0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    wait_cycles(3);
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    drive(1'b0, 16'h80CD, 1'b1);
    wait_idle("overflow", 50);
    exp_log = '{16'h20AB, 16'h4011, 16'h4011, 16'h4011, 16'h80CD, 16'h0, 16'h0, 16'h0};
    check_log("ovf_log", exp_log, 5);
    check("ovf_credit0", cred_cnt[0] - c0, 32'd5);
    check("ovf_still_set", {31'd0, overflow}, 32'd1);

    // turnoff: in-flight packet completes, new single is discarded quietly.
    c0 = cred_cnt[0]; c1 = cred_cnt[1]; m0 = mis_cnt;
    drive(1'b0, 16'h20AB, 1'b1);
    turnoff = 1'b1;
    drive(1'b1, 16'hE012, 1'b0);
    check("turnoff_no_misroute", {31'd0, misroute}, 32'd0);
    drive(1'b0, 16'h80CD, 1'b1);
    wait_idle("turnoff", 50);
    check("turnoff_credit0", cred_cnt[0] - c0, 32'd2);
    check("turnoff_credit1", cred_cnt[1] - c1, 32'd1);
    check("turnoff_misroutes", mis_cnt - m0, 32'd0);
    turnoff = 1'b0;

    // Reset mid-packet discards buffered flits and returns no credits.
    out_ready = 1'b0;
    drive(1'b0, 16'h20AB, 1'b1);
    drive(1'b0, 16'h4011, 1'b1);
    c0 = cred_cnt[0]; c1 = cred_cnt[1];
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_credit", {30'd0, credit}, 32'd0);
    check("midrst_misroute", {31'd0, misroute}, 32'd0);
    check("midrst_overflow", {31'd0, overflow}, 32'd0);
    check("midrst_idle", {31'd0, idle}, 32'd1);
    wait_cycles(8);
    check("midrst_no_credit0", cred_cnt[0] - c0, 32'd0);
    check("midrst_no_credit1", cred_cnt[1] - c1, 32'd0);
    // VC0 is IDLE again, so a lone tail is a protocol error.
    out_ready = 1'b1;
    drive(1'b0, 16'h80CD, 1'b0);
    check("postrst_protocol_error", {31'd0, overflow}, 32'd1);
    wait_cycles(3);
    check("postrst_error_credit", cred_cnt[0] - c0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
